mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle processor control FSM.
- Accepts read/write strobes plus an address and write data from the datapath, then performs the access on an internal word memory after a configurable number of wait states.
- Signals completion with a one-cycle ready pulse, so the control FSM can stall on slow memory instead of assuming single-cycle access.
- Also decodes one memory-mapped I/O word, used for program input and output.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data word width in bits.
- DEPTH, 1024, number of words in the internal memory (valid addresses 0..DEPTH-1).
- WAIT_CYCLES, 2, wait states inserted before the access is committed (0..15).
- IO_ADDR, 16'hFFFF, memory-mapped I/O address; must be >= DEPTH.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-low.
- MemRead  input  1  read request; sampled only in IDLE.
- MemWrite  input  1  write request; sampled only in IDLE.
- Addr  input  ADDR_W  word address, latched when a request is accepted.
- WriteData  input  DATA_W  write data, latched when a request is accepted.
- ReadData  output  DATA_W  registered read result; holds until the next completed read.
- MemReady  output  1  one-cycle completion pulse.
- Busy  output  1  high while a request is in progress.
- Error  output  1  one-cycle pulse, coincident with MemReady, on an illegal access.
- IOIn  input  DATA_W  external input word.
- IOOut  output  DATA_W  registered output word.
- IOOutValid  output  1  one-cycle pulse when IOOut is written.

Behaviour:
- Reset (RST=0 at an edge):
  - State=IDLE; ReadData=0, MemReady=0, Busy=0, Error=0, IOOut=0, IOOutValid=0; wait counter=0.
  - Memory contents are not cleared.
  - Reset mid-request aborts the request; a write whose commit edge has not been reached is never committed.
- State IDLE:
  - At an edge where MemRead|MemWrite=1: latch Addr, WriteData and op; load cnt=WAIT_CYCLES; Busy<=1; go to WAIT.
  - Otherwise remain in IDLE.
- State WAIT:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: commit the access at this edge; MemReady<=1; go to RESP.
- State RESP:
  - At the next edge: MemReady<=0, Error<=0, IOOutValid<=0, Busy<=0; go to IDLE.
  - Requests are not sampled in RESP.
- Latency: request accepted at edge 0, commit at edge WAIT_CYCLES+1, MemReady high for the cycle after it. Earliest next acceptance is edge WAIT_CYCLES+3.
- Commit rules:
  - Read, address < DEPTH: ReadData<=mem[addr].
  - Write, address < DEPTH: mem[addr]<=data.
  - Read of IO_ADDR: ReadData<=IOIn, sampled at the commit edge.
  - Write of IO_ADDR: IOOut<=data; IOOutValid<=1 for one cycle alongside MemReady.
  - Address out of range (not < DEPTH and not IO_ADDR): a read returns ReadData<=0 and a write is dropped; Error pulses with MemReady.
  - MemRead and MemWrite both high at acceptance: no memory or I/O effect, ReadData unchanged; Error pulses with MemReady.
- Address width: only the low ceil(log2(DEPTH)) address bits index the memory, after the range check passes.
- Strobes held high through RESP have no effect. A strobe still high at the following IDLE edge starts a new request, so the controller must drop the strobe once it sees MemReady.

Optional Feature:
- Macro: MEM_STATS_EN.
- When defined, add two ports:
  - ReadCount  output  16: count of successful reads (memory or I/O).
  - WriteCount  output  16: count of successful writes.
  - Both increment at the commit edge, saturate at 16'hFFFF, reset to 0, and are not incremented on Error accesses.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- WAIT_CYCLES=2: write 16'h1234 to addr 5 at edge 0 -> MemReady high only in the cycle after edge 3, Busy high from edge 0 until edge 4. Then read addr 5 -> ReadData=16'h1234 with MemReady.
- WAIT_CYCLES=0: read accepted at edge 0 -> MemReady after edge 1. A back-to-back request held high is accepted at edge 3, not edge 2.
- IOIn=16'h00AB, read IO_ADDR -> ReadData=16'h00AB. Write 16'h0042 to IO_ADDR -> IOOut=16'h0042, IOOutValid pulses once with MemReady.
- Write addr DEPTH (1024) -> Error+MemReady pulse, a subsequent read of addr 0 is unchanged. Read addr 1024 -> ReadData=0, Error=1.
- MemRead=MemWrite=1 at addr 7 holding 16'h5555 -> Error pulse, mem[7] still 16'h5555, ReadData unchanged.
- Write 16'hBEEF to addr 9, assert RST=0 at edge 1 (WAIT_CYCLES=2) -> all outputs 0, state IDLE, later read of addr 9 returns the old value. With MEM_STATS_EN: WriteCount=0 after reset, and 1 after one completed write.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle control FSM.
// Accepts a read or write request in IDLE, waits WAIT_CYCLES edges, commits
// the access to an internal word memory or the memory-mapped I/O word, then
// pulses MemReady (and Error or IOOutValid where they apply) for one cycle.
// Optional feature macro: MEM_STATS_EN adds saturating ReadCount/WriteCount.
`timescale 1ns/1ps

module mem_responder #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       DEPTH       = 1024,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemReady,
  output logic              Busy,
  output logic              Error,
  input  logic [DATA_W-1:0] IOIn,
  output logic [DATA_W-1:0] IOOut,
  output logic              IOOutValid
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]       ReadCount,
  output logic [15:0]       WriteCount
`endif
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_rd, lat_wr;
  logic              commit, in_range, is_io, bad;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem [DEPTH];

  // Decode of the latched request; only meaningful while in WAIT.
  assign commit   = (state == S_WAIT) && (cnt == 4'd0);
  assign in_range = 32'(lat_addr) < 32'(DEPTH);
  assign is_io    = (lat_addr == IO_ADDR);
  assign bad      = (lat_rd && lat_wr) || (!in_range && !is_io);
  assign idx      = lat_addr[IDX_W-1:0];

  // Next-state logic: accept in IDLE, count down in WAIT, one cycle of RESP.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt; no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (MemRead || MemWrite) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd0)         state_nxt = S_RESP;
      S_RESP:                           state_nxt = S_IDLE;
      default:                          state_nxt = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignment for all clocked state so every flop sees pre-edge values.
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Request latch, wait counter and registered response outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt        <= 4'd0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
      ReadData   <= '0;
      MemReady   <= 1'b0;
      Busy       <= 1'b0;
      Error      <= 1'b0;
      IOOut      <= '0;
      IOOutValid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (MemRead || MemWrite) begin
            lat_addr <= Addr;
            lat_data <= WriteData;
            lat_rd   <= MemRead;
            lat_wr   <= MemWrite;
            cnt      <= 4'(WAIT_CYCLES);
            Busy     <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            MemReady <= 1'b1;
            Error    <= bad;
            if (!bad) begin
              if (lat_rd) ReadData <= is_io ? IOIn : mem[idx];
              if (lat_wr && is_io) begin
                IOOut      <= lat_data;
                IOOutValid <= 1'b1;
              end
            end else if (lat_rd && !lat_wr) begin
              // Out-of-range read returns zero; a conflicting request leaves ReadData alone.
              ReadData <= '0;
            end
          end
        end
        S_RESP: begin
          MemReady   <= 1'b0;
          Error      <= 1'b0;
          IOOutValid <= 1'b0;
          Busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Word memory write port; gated by RST so an aborted request never commits.
  always_ff @(posedge CLK) begin
    // NOTE: the memory array is deliberately not reset; contents survive RST.
    if (RST && commit && lat_wr && !lat_rd && in_range) mem[idx] <= lat_data;
  end

`ifdef MEM_STATS_EN
  // Saturating counters of successful reads and writes, bumped at commit.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ReadCount  <= '0;
      WriteCount <= '0;
    end else if (commit && !bad) begin
      if (lat_rd && ReadCount  != 16'hFFFF) ReadCount  <= ReadCount  + 16'd1;
      if (lat_wr && WriteCount != 16'hFFFF) WriteCount <= WriteCount + 16'd1;
    end
  end
`endif

endmodule
